// File: rtl/proc_pkg.sv
// Shared types and default widths for the base processor control sequencer.
package proc_pkg;

   // Default register-select and opcode widths used by the interface and top.
   localparam int DEF_REG_SEL_W = 2;
   localparam int DEF_OPC_W     = 2;
   localparam int DEF_NUM_REGS  = 2 ** DEF_REG_SEL_W;
   localparam int DEF_FUNC_W    = DEF_OPC_W + 2 * DEF_REG_SEL_W;

   // Fixed opcode encoding of the instruction word.
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_MOV  = 2'b01,
      OP_ADD  = 2'b10,
      OP_SUB  = 2'b11
   } opcode_e;

   // Timesteps of the sequencer; every instruction starts in T0.
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_e;

   // Instruction word layout: {opcode, rx, ry}.
   typedef struct packed {
      opcode_e                  opcode;
      logic [DEF_REG_SEL_W-1:0] rx;
      logic [DEF_REG_SEL_W-1:0] ry;
   } ir_t;

endpackage

// File: rtl/proc_control_unit_if.sv
// Instruction-source / datapath-control bundle of the control sequencer.
// The master side supplies start and the instruction word; the slave side
// (the control unit) drives the datapath strobes back.
interface proc_control_unit_if #(
   parameter int REG_SEL_W = proc_pkg::DEF_REG_SEL_W,
   parameter int OPC_W     = proc_pkg::DEF_OPC_W
);
   localparam int NUM_REGS = 2 ** REG_SEL_W;
   localparam int FUNC_W   = OPC_W + 2 * REG_SEL_W;

   logic                w;
   logic [FUNC_W-1:0]   func;
   logic                ir_en;
   logic [NUM_REGS-1:0] rin;
   logic [NUM_REGS-1:0] rout;
   logic                extern_en;
   logic                a_in;
   logic                g_in;
   logic                g_out;
   logic                add_sub;
   logic                done;
   logic [1:0]          step;

   modport master (
      output w, func,
      input  ir_en, rin, rout, extern_en, a_in, g_in, g_out, add_sub, done, step
   );

   modport slave (
      input  w, func,
      output ir_en, rin, rout, extern_en, a_in, g_in, g_out, add_sub, done, step
   );

endinterface

// File: rtl/proc_control_unit_step_counter.sv
// Two-bit timestep counter: async reset, synchronous clear, count enable.
module step_counter (
   input  logic       clock,
   input  logic       clear,
   input  logic       sclr,
   input  logic       en,
   output logic [1:0] step
);

   logic [1:0] step_d;
   logic [1:0] step_q;

   // Next step: synchronous clear wins over counting, otherwise advance by one.
   always_comb begin
      step_d = step_q;
      if (sclr) begin
         step_d = 2'd0;
      end else if (en) begin
         step_d = step_q + 2'd1;
      end
   end

   // Step register, forced back to T0 as soon as clear rises.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         step_q <= 2'd0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/proc_control_unit.sv
// Control sequencer for the base processor datapath: holds the instruction
// register and decodes (step, instruction) into per-step datapath strobes.
module proc_control_unit
   import proc_pkg::*;
#(
   parameter int REG_SEL_W = DEF_REG_SEL_W,
   parameter int OPC_W     = DEF_OPC_W
) (
   input  logic                clock,
   input  logic                clear,
   proc_control_unit_if.slave  bus
);

   localparam int NUM_REGS = 2 ** REG_SEL_W;
   localparam int FUNC_W   = OPC_W + 2 * REG_SEL_W;

   // Encoded step values as plain constants for the decode case.
   localparam logic [1:0] ST_T0 = 2'd0;
   localparam logic [1:0] ST_T1 = 2'd1;
   localparam logic [1:0] ST_T2 = 2'd2;
   localparam logic [1:0] ST_T3 = 2'd3;

   logic [FUNC_W-1:0]    ir_d;
   logic [FUNC_W-1:0]    ir_q;
   logic [1:0]           step;
   logic                 step_sclr;
   logic                 ir_load;
   logic [OPC_W-1:0]     opcode;
   logic [REG_SEL_W-1:0] rx;
   logic [REG_SEL_W-1:0] ry;
   logic                 is_arith;

   logic [NUM_REGS-1:0]  dec_rin;
   logic [NUM_REGS-1:0]  dec_rout;
   logic                 dec_extern_en;
   logic                 dec_a_in;
   logic                 dec_g_in;
   logic                 dec_g_out;
   logic                 dec_add_sub;
   logic                 dec_done;

   // Register select to one-hot enable.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
      logic [NUM_REGS-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

   assign opcode   = ir_q[FUNC_W-1 -: OPC_W];
   assign rx       = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
   assign ry       = ir_q[REG_SEL_W-1:0];
   assign is_arith = (opcode == OPC_W'(OP_ADD)) || (opcode == OPC_W'(OP_SUB));

   // Start is only honoured in T0, and never while clear is held.
   assign ir_load = (step == ST_T0) && bus.w && !clear;

   // Return to T0 after the done cycle, or stay there while idle.
   assign step_sclr = dec_done || ((step == ST_T0) && !bus.w);

   step_counter u_step_counter (
      .clock (clock),
      .clear (clear),
      .sclr  (step_sclr),
      .en    (1'b1),
      .step  (step)
   );

   // Next instruction word: capture func on an accepted start, else hold.
   always_comb begin
      ir_d = ir_q;
      if (ir_load) begin
         ir_d = bus.func;
      end
   end

   // Instruction register, cleared to zero by the async reset.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         ir_q <= '0;
      end else begin
         ir_q <= ir_d;
      end
   end

   // Per-step strobe decode. T3 always finishes an instruction, so done
   // there (and in T2 for single-step opcodes) guarantees a return to T0.
   always_comb begin
      dec_rin       = '0;
      dec_rout      = '0;
      dec_extern_en = 1'b0;
      dec_a_in      = 1'b0;
      dec_g_in      = 1'b0;
      dec_g_out     = 1'b0;
      dec_add_sub   = 1'b0;
      dec_done      = 1'b0;
      case (step)
         ST_T1: begin
            if (opcode == OPC_W'(OP_LOAD)) begin
               dec_extern_en = 1'b1;
               dec_rin       = reg_onehot(rx);
               dec_done      = 1'b1;
            end else if (opcode == OPC_W'(OP_MOV)) begin
               dec_rout = reg_onehot(ry);
               dec_rin  = reg_onehot(rx);
               dec_done = 1'b1;
            end else begin
               dec_rout = reg_onehot(rx);
               dec_a_in = 1'b1;
            end
         end
         ST_T2: begin
            if (is_arith) begin
               dec_rout    = reg_onehot(ry);
               dec_g_in    = 1'b1;
               dec_add_sub = (opcode == OPC_W'(OP_SUB));
            end else begin
               dec_done = 1'b1;
            end
         end
         ST_T3: begin
            if (is_arith) begin
               dec_g_out = 1'b1;
               dec_rin   = reg_onehot(rx);
            end
            dec_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.ir_en     = ir_load;
   assign bus.rin       = dec_rin;
   assign bus.rout      = dec_rout;
   assign bus.extern_en = dec_extern_en;
   assign bus.a_in      = dec_a_in;
   assign bus.g_in      = dec_g_in;
   assign bus.g_out     = dec_g_out;
   assign bus.add_sub   = dec_add_sub;
   assign bus.done      = dec_done;
   assign bus.step      = step;

endmodule
